// File: rtl/bht_update_queue.sv
// In-order queue of predicted branches. When a branch resolves, the head entry is popped
// and one registered BHT write goes out, carrying the BHT row index saved at prediction time.
// bht_update_o is packed as {valid, pc[VLEN-1:0], taken}.
module bht_update_queue #(
  parameter int unsigned VLEN           = 64,
  parameter int unsigned BHT_INDEX_BITS = 7,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      debug_mode_i,
  input  logic                      push_valid_i,
  output logic                      push_ready_o,
  input  logic [VLEN-1:0]           push_pc_i,
  input  logic [BHT_INDEX_BITS-1:0] push_index_i,
  input  logic                      push_taken_i,
  input  logic                      resolve_valid_i,
  input  logic [VLEN-1:0]           resolve_pc_i,
  input  logic                      resolve_taken_i,
  output logic [VLEN+1:0]           bht_update_o,
  output logic [BHT_INDEX_BITS-1:0] update_index_o,
  output logic                      mispredict_o,
  output logic                      mismatch_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [VLEN-1:0]           mem_pc    [DEPTH];
  logic [BHT_INDEX_BITS-1:0] mem_idx   [DEPTH];
  logic                      mem_taken [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;

  logic                      upd_valid, upd_taken;
  logic [VLEN-1:0]           upd_pc;
  logic [BHT_INDEX_BITS-1:0] upd_idx;

  logic empty, head_match, push_acc, pop, upd;

  assign empty        = (count == '0);
  assign push_ready_o = (count != FULL);
  assign push_acc     = push_valid_i & push_ready_o & ~flush_i;
  assign head_match   = (resolve_pc_i == mem_pc[head]);
  // Resolve sees start-of-cycle state only, so a same-cycle push can never be popped.
  assign pop          = resolve_valid_i & ~empty;
  assign upd          = pop & head_match & ~debug_mode_i;

  assign bht_update_o   = {upd_valid, upd_pc, upd_taken};
  assign update_index_o = upd_idx;
  assign count_o        = count;

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_pc[tail]    <= push_pc_i;
      mem_idx[tail]   <= push_index_i;
      mem_taken[tail] <= push_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc) tail <= tail + PW'(1);
      if (pop)      head <= head + PW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload holds its last value when no update is issued.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      upd_valid    <= 1'b0;
      upd_pc       <= '0;
      upd_taken    <= 1'b0;
      upd_idx      <= '0;
      mispredict_o <= 1'b0;
      mismatch_o   <= 1'b0;
    end else begin
      upd_valid    <= upd;
      mispredict_o <= upd & (resolve_taken_i != mem_taken[head]);
      mismatch_o   <= resolve_valid_i & (empty | ~head_match);
      if (upd) begin
        upd_pc    <= mem_pc[head];
        upd_taken <= resolve_taken_i;
        upd_idx   <= mem_idx[head];
      end
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: a reference queue model predicts each cycle's
// outputs, which are queued at drive time and compared after the clock edge.
module tb_bht_update_queue;

  localparam int VLEN = 64;
  localparam int IB   = 7;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n, flush, dbg, pv, pt, rv, rt;
  logic [VLEN-1:0] ppc, rpc;
  logic [IB-1:0]   pidx;
  logic            ready, mispr, mism;
  logic [VLEN+1:0] upd;
  logic [IB-1:0]   uidx;
  logic [3:0]      cnt;

  always #5 clk = ~clk;

  bht_update_queue #(.VLEN(VLEN), .BHT_INDEX_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(dbg),
    .push_valid_i(pv), .push_ready_o(ready), .push_pc_i(ppc), .push_index_i(pidx),
    .push_taken_i(pt), .resolve_valid_i(rv), .resolve_pc_i(rpc), .resolve_taken_i(rt),
    .bht_update_o(upd), .update_index_o(uidx), .mispredict_o(mispr), .mismatch_o(mism),
    .count_o(cnt)
  );

  typedef struct { logic [VLEN-1:0] pc; logic [IB-1:0] idx; logic t; } ent_t;
  typedef struct {
    logic v; logic [VLEN-1:0] pc; logic [IB-1:0] idx; logic t;
    logic mp; logic mm; int cnt; logic rdy;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  logic [VLEN-1:0] hpc;
  logic [IB-1:0]   hidx;
  logic            ht;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] ex);
    checks++;
    if (obs !== ex) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, ex, $time);
    end
  endtask

  // One clock: model the cycle, push the expectation, clock, pop and compare.
  task automatic step(input bit r, input bit f, input bit d,
                      input bit p, input logic [VLEN-1:0] pc, input logic [IB-1:0] ix, input bit ptk,
                      input bit res, input logic [VLEN-1:0] rp, input bit rtk);
    exp_t e;
    ent_t h, n;
    bit rdy0;
    rst_n = ~r; flush = f; dbg = d; pv = p; ppc = pc; pidx = ix; pt = ptk;
    rv = res; rpc = rp; rt = rtk;
    e = '{v:0, pc:0, idx:0, t:0, mp:0, mm:0, cnt:0, rdy:1};
    if (r) begin
      mq.delete(); hpc = '0; hidx = '0; ht = 1'b0;
    end else begin
      rdy0 = (mq.size() != DEPTH);
      if (res) begin
        if (mq.size() == 0) e.mm = 1;
        else begin
          h = mq.pop_front();
          if (h.pc != rp) e.mm = 1;
          else if (!d) begin
            e.v = 1; hpc = h.pc; hidx = h.idx; ht = rtk; e.mp = (rtk != h.t);
          end
        end
      end
      if (p && rdy0 && !f) begin
        n.pc = pc; n.idx = ix; n.t = ptk; mq.push_back(n);
      end
      if (f) mq.delete();
    end
    e.pc = hpc; e.idx = hidx; e.t = ht;
    e.cnt = mq.size(); e.rdy = (mq.size() != DEPTH);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("upd_valid", VLEN'(upd[VLEN+1]), VLEN'(e.v));
    chk("upd_pc",    upd[VLEN:1],        e.pc);
    chk("upd_taken", VLEN'(upd[0]),      VLEN'(e.t));
    chk("upd_index", VLEN'(uidx),        VLEN'(e.idx));
    chk("mispredict", VLEN'(mispr),      VLEN'(e.mp));
    chk("mismatch",  VLEN'(mism),        VLEN'(e.mm));
    chk("count",     VLEN'(cnt),         VLEN'(e.cnt));
    chk("ready",     VLEN'(ready),       VLEN'(e.rdy));
  endtask

  task automatic push(input logic [VLEN-1:0] pc, input logic [IB-1:0] ix, input bit tk);
    step(0, 0, 0, 1, pc, ix, tk, 0, 0, 0);
  endtask
  task automatic resolve(input logic [VLEN-1:0] pc, input bit tk);
    step(0, 0, 0, 0, 0, 0, 0, 1, pc, tk);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hpc = '0; hidx = '0; ht = 1'b0;
    rst_n = 0; flush = 0; dbg = 0; pv = 0; pt = 0; rv = 0; rt = 0;
    ppc = '0; rpc = '0; pidx = '0;
    // Reset wins even with push/resolve asserted.
    step(1, 0, 0, 1, 64'h40, 1, 1, 1, 64'h40, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic push/resolve with mispredict.
    push(64'h80, 5, 0);
    resolve(64'h80, 1);
    idle();

    // Fill, refused push while full with concurrent pop, drain, then wrap.
    for (int i = 0; i < DEPTH; i++) push(64'h1000 + 64'(i*4), IB'(i), i[0]);
    step(0, 0, 0, 1, 64'hdead, 9, 1, 1, 64'h1000, 0);
    for (int i = 1; i < DEPTH; i++) resolve(64'h1000 + 64'(i*4), ~i[0]);
    for (int i = 0; i < DEPTH; i++) push(64'h2000 + 64'(i*8), IB'(i + 20), ~i[0]);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 64'h3000 + 64'(i), IB'(i + 40), 1,
                                         1, 64'h2000 + 64'(i*8), ~i[0]);
    for (int i = 0; i < DEPTH; i++) resolve(64'h3000 + 64'(i), i[1]);

    // Empty resolve, then PC mismatch on head.
    resolve(64'h55, 1);
    idle();
    push(64'h100, 3, 1);
    push(64'h200, 4, 0);
    resolve(64'h104, 1);
    resolve(64'h200, 0);

    // Flush with resolve and push in the same cycle.
    push(64'h300, 11, 1);
    push(64'h304, 12, 0);
    push(64'h308, 13, 1);
    step(0, 1, 0, 1, 64'h30c, 14, 1, 1, 64'h300, 0);
    idle();
    resolve(64'h304, 0);

    // Debug mode suppresses the write but still pops.
    push(64'h400, 21, 1);
    push(64'h404, 22, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1, 64'h400, 0);
    resolve(64'h404, 1);

    // Mid-stream reset with a resolve pending.
    for (int i = 0; i < 4; i++) push(64'h500 + 64'(i*4), IB'(i + 50), 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 64'h500, 0);
    idle();
    resolve(64'h504, 1);

    // Random mix, mostly resolving the true head.
    for (int i = 0; i < 200; i++) begin
      logic [VLEN-1:0] rp;
      bit res;
      res = ($urandom_range(0, 2) == 0);
      rp = (mq.size() != 0 && $urandom_range(0, 5) != 0) ? mq[0].pc : VLEN'($urandom_range(0, 15) * 4);
      step(0, ($urandom_range(0, 30) == 0), ($urandom_range(0, 8) == 0),
           $urandom_range(0, 1), VLEN'($urandom_range(0, 15) * 4), IB'($urandom), $urandom_range(0, 1),
           res, rp, $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
